// File: rtl/seg_scan_ctrl.sv
// Seven-segment sequencer for the switch-adder board: synchronises and snapshots
// the operands, converts A, B and A+B to BCD serially, and scans all 8 digits.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] op_a,
    input  logic [5:0] op_b,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       busy,
    output logic       conv_done
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_DASH  = 7'b011_1111;
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV_A,
        CONV_B,
        CONV_S,
        COMMIT
    } state_t;

    logic [9:0]  aMeta_q, aSync_q;
    logic [5:0]  bMeta_q, bSync_q;

    state_t      state_q;
    logic [15:0] snap_q;
    logic        snapValid_q;
    logic [10:0] sum_q;
    logic [15:0] bcd_q;
    logic [10:0] bin_q;
    logic [3:0]  bitCnt_q;
    logic [15:0] tmpA_q, tmpS_q;
    logic [7:0]  tmpB_q;
    logic [15:0] dispA_q, dispS_q;
    logic [7:0]  dispB_q;
    logic        busy_q, convDone_q;

    logic [CNT_W-1:0] scanCnt_q;
    logic [2:0]  digitIdx_q;
    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;

    logic [15:0] bcdAdj;
    logic [15:0] bcdShift_d;
    logic [10:0] binShift_d;
    logic [2:0]  nextIdx_d;
    logic [7:0]  anNext_d;
    logic [6:0]  segNext_d;
    logic        dpNext_d;
    logic [3:0]  nibble;
    logic        dash;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b100_0000;
            4'd1:    decode = 7'b111_1001;
            4'd2:    decode = 7'b010_0100;
            4'd3:    decode = 7'b011_0000;
            4'd4:    decode = 7'b001_1001;
            4'd5:    decode = 7'b001_0010;
            4'd6:    decode = 7'b000_0010;
            4'd7:    decode = 7'b111_1000;
            4'd8:    decode = 7'b000_0000;
            4'd9:    decode = 7'b001_0000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aMeta_q <= '0;
            aSync_q <= '0;
            bMeta_q <= '0;
            bSync_q <= '0;
        end else begin
            aMeta_q <= op_a;
            aSync_q <= aMeta_q;
            bMeta_q <= op_b;
            bSync_q <= bMeta_q;
        end
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        bcdAdj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcdShift_d = 16'({bcdAdj, bin_q[10]});
        binShift_d = {bin_q[9:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            snapValid_q <= 1'b0;
            sum_q       <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            bitCnt_q    <= '0;
            tmpA_q      <= '0;
            tmpB_q      <= '0;
            tmpS_q      <= '0;
            dispA_q     <= '0;
            dispB_q     <= '0;
            dispS_q     <= '0;
            busy_q      <= 1'b0;
            convDone_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!snapValid_q || ({aSync_q, bSync_q} != snap_q)) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    snap_q   <= {aSync_q, bSync_q};
                    sum_q    <= {1'b0, aSync_q} + {5'b0, bSync_q};
                    bcd_q    <= '0;
                    bin_q    <= {aSync_q, 1'b0};
                    bitCnt_q <= '0;
                    state_q  <= CONV_A;
                end
                CONV_A: begin
                    bcd_q    <= bcdShift_d;
                    bin_q    <= binShift_d;
                    bitCnt_q <= bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd9) begin
                        tmpA_q   <= bcdShift_d;
                        bcd_q    <= '0;
                        bin_q    <= {snap_q[5:0], 5'b0};
                        bitCnt_q <= '0;
                        state_q  <= CONV_B;
                    end
                end
                CONV_B: begin
                    bcd_q    <= bcdShift_d;
                    bin_q    <= binShift_d;
                    bitCnt_q <= bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd5) begin
                        tmpB_q   <= bcdShift_d[7:0];
                        bcd_q    <= '0;
                        bin_q    <= sum_q;
                        bitCnt_q <= '0;
                        state_q  <= CONV_S;
                    end
                end
                CONV_S: begin
                    bcd_q    <= bcdShift_d;
                    bin_q    <= binShift_d;
                    bitCnt_q <= bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd10) begin
                        tmpS_q     <= bcdShift_d;
                        convDone_q <= 1'b1;
                        state_q    <= COMMIT;
                    end
                end
                COMMIT: begin
                    dispA_q     <= tmpA_q;
                    dispB_q     <= tmpB_q;
                    dispS_q     <= tmpS_q;
                    snapValid_q <= 1'b1;
                    convDone_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Segment pattern for the digit that becomes active on the next wrap.
    always_comb begin
        nextIdx_d = 3'(digitIdx_q + 3'd1);
        anNext_d  = ~(8'h80 >> nextIdx_d);
        dpNext_d  = !((nextIdx_d == 3'd2) || (nextIdx_d == 3'd4));
        nibble    = 4'd0;
        dash      = 1'b0;
        case (nextIdx_d)
            3'd0: begin nibble = dispA_q[11:8]; dash = (dispA_q[15:12] != 4'd0); end
            3'd1: begin nibble = dispA_q[7:4];  dash = (dispA_q[15:12] != 4'd0); end
            3'd2: begin nibble = dispA_q[3:0];  dash = (dispA_q[15:12] != 4'd0); end
            3'd3: nibble = dispB_q[7:4];
            3'd4: nibble = dispB_q[3:0];
            3'd5: begin nibble = dispS_q[11:8]; dash = (dispS_q[15:12] != 4'd0); end
            3'd6: begin nibble = dispS_q[7:4];  dash = (dispS_q[15:12] != 4'd0); end
            default: begin nibble = dispS_q[3:0]; dash = (dispS_q[15:12] != 4'd0); end
        endcase
        segNext_d = dash ? SEG_DASH : decode(nibble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt_q  <= '0;
            digitIdx_q <= '0;
            an_q       <= 8'hFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else if (scanCnt_q == CNT_MAX) begin
            scanCnt_q  <= '0;
            digitIdx_q <= nextIdx_d;
            an_q       <= anNext_d;
            seg_q      <= segNext_d;
            dp_q       <= dpNext_d;
        end else begin
            scanCnt_q <= scanCnt_q + 1'b1;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign busy      = busy_q;
    assign conv_done = convDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: decimal reference model, directed and random operands.
module tb_seg_scan_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] op_a;
    logic [5:0] op_b;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       busy;
    logic       conv_done;

    int errors = 0;
    int checks = 0;
    int curA = 0;
    int curB = 0;

    logic [6:0] capSeg [8];
    logic       capDp  [8];
    bit         capSeen[8];
    int         capBadOneHot;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b),
        .seg(seg), .dp(dp), .an(an), .busy(busy), .conv_done(conv_done)
    );

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segments for scan index idx, straight from decimal arithmetic.
    function automatic logic [6:0] expSeg(input int idx, input int a, input int b);
        int s = a + b;
        case (idx)
            0: return (a > 999) ? 7'b011_1111 : segOf((a / 100) % 10);
            1: return (a > 999) ? 7'b011_1111 : segOf((a / 10) % 10);
            2: return (a > 999) ? 7'b011_1111 : segOf(a % 10);
            3: return segOf(b / 10);
            4: return segOf(b % 10);
            5: return (s > 999) ? 7'b011_1111 : segOf((s / 100) % 10);
            6: return (s > 999) ? 7'b011_1111 : segOf((s / 10) % 10);
            default: return (s > 999) ? 7'b011_1111 : segOf(s % 10);
        endcase
    endfunction

    function automatic logic expDp(input int idx);
        return !((idx == 2) || (idx == 4));
    endfunction

    function automatic int anPos(input logic [7:0] pat);
        logic [7:0] ref8;
        for (int i = 0; i < 8; i++) begin
            ref8 = ~(8'h80 >> i);
            if (pat === ref8) return i;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic capture;
        int p;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) capSeen[i] = 1'b0;
        capBadOneHot = 0;
        repeat (10 * SD) begin
            tick();
            p = anPos(an);
            if (p < 0) capBadOneHot++;
            else begin
                capSeg[p]  = seg;
                capDp[p]   = dp;
                capSeen[p] = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int maxCycles, input bit seenBefore, output bit ok);
        bit seenDone = seenBefore;
        int low = 0;
        ok = 1'b0;
        for (int n = 0; n < maxCycles; n++) begin
            tick();
            if (conv_done) seenDone = 1'b1;
            if (!busy) low++;
            else low = 0;
            if (seenDone && low >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) tick();
        checks++; if (an !== 8'hFF) begin errors++; $display("[TB] FAIL reset_an: got %h want ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg: got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b want 1", dp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (conv_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", conv_done); end
    endtask

    task automatic test_first_conversion;
        int n = 0;
        int cnt = 0;
        int pulses = 0;
        int extra = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        while (n < 10 && busy !== 1'b1) begin tick(); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy_rise: got %b want 1 within 10 cycles", busy); end
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (conv_done === 1'b1) pulses++;
            tick();
        end
        checks++; if (cnt != 29) begin errors++; $display("[TB] FAIL first_busy_len: got %0d want 29", cnt); end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL first_done_pulses: got %0d want 1", pulses); end
        repeat (10) begin tick(); if (busy !== 1'b0) extra++; end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL first_no_reconvert: got %0d busy cycles want 0", extra); end
        capture();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!capSeen[i] || capSeg[i] !== 7'b100_0000) begin
                errors++; $display("[TB] FAIL zero_seg[%0d]: got %b seen=%0d want 1000000", i, capSeg[i], capSeen[i]);
            end
            checks++;
            if (!capSeen[i] || capDp[i] !== expDp(i)) begin
                errors++; $display("[TB] FAIL zero_dp[%0d]: got %b want %b", i, capDp[i], expDp(i));
            end
        end
        checks++; if (capBadOneHot != 0) begin errors++; $display("[TB] FAIL zero_onehot: got %0d bad samples want 0", capBadOneHot); end
    endtask

    task automatic test_values(input int a, input int b);
        int n = 0;
        bit got = 1'b0;
        bit ok;
        op_a = 10'(a);
        op_b = 6'(b);
        curA = a;
        curB = b;
        while (n < 40 && !got) begin
            tick();
            n++;
            if (conv_done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n > 32) begin errors++; $display("[TB] FAIL latency a=%0d b=%0d: got %0d cycles seen=%0d want <=32", a, b, n, got); end
        wait_idle(80, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL idle a=%0d b=%0d: got busy want idle", a, b); end
        capture();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!capSeen[i] || capSeg[i] !== expSeg(i, a, b)) begin
                errors++; $display("[TB] FAIL digit a=%0d b=%0d idx%0d: got %b want %b", a, b, i, capSeg[i], expSeg(i, a, b));
            end
            checks++;
            if (!capSeen[i] || capDp[i] !== expDp(i)) begin
                errors++; $display("[TB] FAIL dp a=%0d b=%0d idx%0d: got %b want %b", a, b, i, capDp[i], expDp(i));
            end
        end
        checks++; if (capBadOneHot != 0) begin errors++; $display("[TB] FAIL onehot a=%0d b=%0d: got %0d bad want 0", a, b, capBadOneHot); end
    endtask

    task automatic test_random;
        int a, b;
        for (int r = 0; r < 4; r++) begin
            a = int'($urandom_range(0, 1023));
            b = int'($urandom_range(0, 63));
            if (a == curA && b == curB) b = (b + 1) % 64;
            test_values(a, b);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int pulses = 0;
        int gap = 0;
        int k = 0;
        int low = 0;
        int p;
        int badWin = 0;
        int badPartial = 0;
        bit sawWin = 1'b0;
        bit ok = 1'b0;
        op_a = 10'd200;
        while (n < 10 && busy !== 1'b1) begin tick(); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_rise: got %b want 1", busy); end
        repeat (3) tick();
        op_b = 6'd7;
        for (n = 0; n < 150; n++) begin
            tick();
            if (conv_done === 1'b1) begin pulses++; k = 0; end
            else if (pulses == 1) k++;
            if (pulses == 1 && busy === 1'b0) gap++;
            p = anPos(an);
            if (p >= 0) begin
                if (seg !== expSeg(p, 100, 5) && seg !== expSeg(p, 200, 5) && seg !== expSeg(p, 200, 7)) badPartial++;
                if (pulses == 1 && k >= 6 && (p == 4 || p == 7)) begin
                    sawWin = 1'b1;
                    if (seg !== expSeg(p, 200, 5)) badWin++;
                end
            end
            if (busy === 1'b0) low++;
            else low = 0;
            if (pulses >= 2 && low >= 3) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_idle: got busy want idle after two commits"); end
        checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d want 2", pulses); end
        checks++; if (gap != 1) begin errors++; $display("[TB] FAIL b2b_gap: got %0d idle cycles want 1", gap); end
        checks++; if (!sawWin || badWin != 0) begin errors++; $display("[TB] FAIL b2b_old_snapshot: got seen=%0d bad=%0d want seen=1 bad=0", sawWin, badWin); end
        checks++; if (badPartial != 0) begin errors++; $display("[TB] FAIL b2b_partial: got %0d bad samples want 0", badPartial); end
        curA = 200;
        curB = 7;
        capture();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!capSeen[i] || capSeg[i] !== expSeg(i, 200, 7)) begin
                errors++; $display("[TB] FAIL b2b_digit idx%0d: got %b want %b", i, capSeg[i], expSeg(i, 200, 7));
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        logic [7:0] an3, an4;
        bit ok;
        op_a = 10'd777;
        op_b = 6'd33;
        curA = 777;
        curB = 33;
        while (n < 10 && busy !== 1'b1) begin tick(); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy_rise: got %b want 1", busy); end
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("[TB] FAIL rmid_an: got %h want ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL rmid_seg: got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("[TB] FAIL rmid_dp: got %b want 1", dp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (conv_done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done: got %b want 0", conv_done); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        tick();
        an3 = an;
        tick();
        an4 = an;
        checks++; if (an3 !== 8'hFF) begin errors++; $display("[TB] FAIL rmid_prewrap_an: got %h want ff", an3); end
        checks++; if (an4 !== 8'b1011_1111) begin errors++; $display("[TB] FAIL rmid_firstwrap_an: got %b want 10111111", an4); end
        wait_idle(150, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_idle: got busy want idle"); end
        capture();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (!capSeen[i] || capSeg[i] !== expSeg(i, 777, 33)) begin
                errors++; $display("[TB] FAIL rmid_digit idx%0d: got %b want %b", i, capSeg[i], expSeg(i, 777, 33));
            end
        end
    endtask

    task automatic test_scan_timing;
        logic [7:0] prev = an;
        int runLen = 1;
        int runs = 0;
        int badLen = 0;
        int badOrder = 0;
        int badOneHot = 0;
        bit partial = 1'b1;
        repeat (120) begin
            tick();
            if (anPos(an) < 0) badOneHot++;
            if (an !== prev) begin
                if (!partial) begin
                    runs++;
                    if (runLen != SD) badLen++;
                end
                if (anPos(an) != (anPos(prev) + 1) % 8) badOrder++;
                partial = 1'b0;
                prev = an;
                runLen = 1;
            end else begin
                runLen++;
            end
        end
        checks++; if (runs < 20) begin errors++; $display("[TB] FAIL scan_runs: got %0d want >=20", runs); end
        checks++; if (badLen != 0) begin errors++; $display("[TB] FAIL scan_hold: got %0d bad runs want 0", badLen); end
        checks++; if (badOrder != 0) begin errors++; $display("[TB] FAIL scan_order: got %0d bad steps want 0", badOrder); end
        checks++; if (badOneHot != 0) begin errors++; $display("[TB] FAIL scan_onehot: got %0d bad samples want 0", badOneHot); end
    endtask

    initial begin
        test_reset();
        test_first_conversion();
        test_values(456, 63);
        test_values(999, 1);
        test_values(1023, 5);
        test_random();
        test_values(100, 5);
        test_back_to_back();
        test_reset_mid();
        test_scan_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
